// File: rtl/signed_rebuild_pkg.sv
// signed_rebuild_pkg: shared constants and saturation limits for the sign-magnitude rebuilder
package signed_rebuild_pkg;
  localparam int fifo_depth = 4;
  localparam int cnt_width = 16;
  function automatic logic [63:0] sat_max(int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
  function automatic logic [63:0] sat_min(int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/signed_rebuild_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO, head visible whenever not empty
module sync_fifo_fwft #(
  parameter int width = 16,
  parameter int depth = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [width-1:0]             push_data,
  input  logic                         pop,
  output logic [width-1:0]             head,
  output logic                         valid,
  output logic [$clog2(depth+1)-1:0]   count
);
  localparam int aw = $clog2(depth);
  localparam int cw = $clog2(depth + 1);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  always_comb begin
    valid = count != '0;
    rd_en = pop && valid;
    wr_en = push && (int'(count) < depth || rd_en);
    head = mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      for (int i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= int'(wr_ptr) == depth - 1 ? '0 : wr_ptr + 1'b1;
      end
      if (rd_en) rd_ptr <= int'(rd_ptr) == depth - 1 ? '0 : rd_ptr + 1'b1;
      count <= count + cw'(wr_en) - cw'(rd_en);
    end
  end
endmodule

// File: rtl/signed_rebuild.sv
// signed_rebuild: sign-magnitude to saturated two's-complement converter with FIFO output
module signed_rebuild
  import signed_rebuild_pkg::*;
#(
  parameter int data_width = 16,
  parameter int sign_delay = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [data_width-1:0] mag_i,
  input  logic                  sign_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [data_width-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  input  logic                  sat_clr_i,
  output logic [cnt_width-1:0]  sat_count_o
);
  localparam logic [data_width-1:0] max_v = data_width'(sat_max(data_width));
  localparam logic [data_width-1:0] min_v = data_width'(sat_min(data_width));
  localparam int cw = $clog2(fifo_depth + 1);
  logic [2:0] sign_sr;
  logic [3:0] taps;
  logic sign, msb, sat, in_xfer, stage_v;
  logic [data_width-1:0] conv, stage_d;
  logic [cw-1:0] fifo_count;
  // the stage register counts toward capacity so the FIFO can never overflow
  assign ready_o = int'(fifo_count) + int'(stage_v) < fifo_depth;
  always_comb begin
    taps = {sign_sr, sign_i};
    sign = taps[2'(sign_delay)];
    msb = mag_i[data_width-1];
    sat = sign ? msb && (|mag_i[data_width-2:0]) : msb;
    conv = sat ? (sign ? min_v : max_v) : (sign ? -mag_i : mag_i);
    in_xfer = valid_i && ready_o;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_v <= 1'b0;
      stage_d <= '0;
      sign_sr <= '0;
      sat_count_o <= '0;
    end else begin
      stage_v <= in_xfer;
      if (in_xfer) begin
        stage_d <= conv;
        sign_sr <= {sign_sr[1:0], sign_i};
      end
      sat_count_o <= sat_clr_i ? cnt_width'(in_xfer && sat)
                   : (in_xfer && sat && !(&sat_count_o)) ? sat_count_o + 1'b1 : sat_count_o;
    end
  end
  sync_fifo_fwft #(.width(data_width), .depth(fifo_depth)) fifo (
    .clk(clk_i),
    .rst(rst_i),
    .push(stage_v),
    .push_data(stage_d),
    .pop(ready_i),
    .head(data_o),
    .valid(valid_o),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_signed_rebuild.sv
// tb_signed_rebuild: scoreboard bench for signed_rebuild (delay 0 and delay 2 instances)
module tb_signed_rebuild;
  logic clk = 1'b0, rst_i = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] mag_i = '0, mag2 = '0;
  logic sign_i = 1'b0, valid_i = 1'b0, ready_i = 1'b1, sat_clr_i = 1'b0;
  logic sign2 = 1'b0, valid2 = 1'b0, ready2 = 1'b1, sat_clr2 = 1'b0;
  logic ready_o, valid_o, ready2_o, valid2_o;
  logic [15:0] data_o, sat_count_o, data2_o, sat2_o;
  int checks = 0, failures = 0;
  logic [15:0] q[$], q2[$], out2[$];
  logic [2:0] sr2 = '0;
  logic [15:0] exp_sat = '0, sat_nxt = '0;

  signed_rebuild #(.data_width(16), .sign_delay(0)) dut (
    .clk_i(clk), .rst_i(rst_i), .mag_i(mag_i), .sign_i(sign_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .sat_clr_i(sat_clr_i), .sat_count_o(sat_count_o));

  signed_rebuild #(.data_width(16), .sign_delay(2)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .mag_i(mag2), .sign_i(sign2), .valid_i(valid2),
    .ready_o(ready2_o), .data_o(data2_o), .valid_o(valid2_o), .ready_i(ready2),
    .sat_clr_i(sat_clr2), .sat_count_o(sat2_o));

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] model(logic [15:0] m, logic s);
    int v;
    v = s ? -int'(m) : int'(m);
    if (v > 32767) return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
    return {1'b0, v[15:0]};
  endfunction

  // outputs are compared against the current edge, predictions target the next edge
  always @(negedge clk) begin
    logic [16:0] r;
    logic x;
    if (rst_i) begin
      q.delete();
      q2.delete();
      sr2 = '0;
      sat_nxt = '0;
    end else begin
      if (valid_o && ready_i) begin
        if (q.size() == 0) check("unexpected_out", 32'(valid_o), 0);
        else check("data", data_o, q.pop_front());
      end
      if (valid2_o && ready2) begin
        out2.push_back(data2_o);
        if (q2.size() == 0) check("unexpected_out2", 32'(valid2_o), 0);
        else check("data2", data2_o, q2.pop_front());
      end
      r = model(mag_i, sign_i);
      x = valid_i && ready_o;
      if (x) q.push_back(r[15:0]);
      sat_nxt = sat_clr_i ? {15'b0, x && r[16]} : (x && r[16] && exp_sat != 16'hFFFF) ? exp_sat + 16'd1 : exp_sat;
      if (valid2 && ready2_o) begin
        r = model(mag2, sr2[1]);
        q2.push_back(r[15:0]);
        sr2 = {sr2[1:0], sign2};
      end
    end
  end
  always @(posedge clk) exp_sat = sat_nxt;

  task automatic send(logic [15:0] m, logic s);
    int t = 0;
    bit done = 1'b0;
    mag_i = m;
    sign_i = s;
    valid_i = 1'b1;
    while (!done && t < 50) begin
      @(negedge clk);
      done = ready_o;
      @(posedge clk);
      #1;
      t++;
    end
    if (!done) check("send_timeout", 32'(ready_o), 1);
  endtask

  task automatic idle(int n);
    valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, cyc;
    logic hold_ok;
    logic [15:0] h;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready_o), 1);
    check("rst_valid", 32'(valid_o), 0);
    check("rst_data", data_o, 0);
    check("rst_sat", sat_count_o, 0);
    @(posedge clk);
    #1;
    mag_i = 16'd5; sign_i = 1'b0; valid_i = 1'b1;
    @(posedge clk);
    #1 valid_i = 1'b0;
    @(negedge clk);
    check("lat_k", 32'(valid_o), 0);
    @(negedge clk);
    check("lat_k1_valid", 32'(valid_o), 1);
    check("lat_k1_data", data_o, 16'd5);
    idle(3);
    send(16'd5, 1'b0); send(16'd5, 1'b1); send(16'd0, 1'b1);
    idle(1);
    wait_drain();
    check("sat_none", sat_count_o, 0);
    send(16'h8000, 1'b0); send(16'h8000, 1'b1); send(16'h8001, 1'b1);
    idle(1);
    wait_drain();
    check("sat_two", sat_count_o, 2);
    check("sat_model", sat_count_o, exp_sat);
    ready_i = 1'b0;
    valid_i = 1'b1; mag_i = 16'd100; sign_i = 1'b0; n = 0;
    repeat (8) begin
      logic a;
      @(negedge clk);
      a = ready_o;
      if (a) n++;
      @(posedge clk);
      #1 if (a) mag_i = mag_i + 16'd1;
    end
    valid_i = 1'b0;
    check("bp_xfers", n, 4);
    @(negedge clk);
    check("bp_ready_low", 32'(ready_o), 0);
    h = data_o;
    hold_ok = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (data_o !== h || valid_o !== 1'b1) hold_ok = 1'b0;
    end
    check("bp_head_stable", data_o, h);
    check("bp_valid_hold", 32'(hold_ok && valid_o), 1);
    @(posedge clk);
    #1 ready_i = 1'b1;
    @(negedge clk);
    check("bp_ready_before_read", 32'(ready_o), 0);
    @(negedge clk);
    check("bp_ready_after_read", 32'(ready_o), 1);
    wait_drain();
    mag2 = 16'd7; sign2 = 1'b1; valid2 = 1'b1;
    @(posedge clk);
    #1 sign2 = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 valid2 = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("sd2_count", out2.size(), 3);
    if (out2.size() >= 3) check("sd2_third", out2[2], 16'hFFF9);
    check("sd2_first", out2.size() > 0 ? out2[0] : 16'hDEAD, 16'd7);
    ready_i = 1'b0;
    send(16'd7, 1'b0); send(16'd8, 1'b1); send(16'd9, 1'b0);
    idle(3);
    check("queued_valid", 32'(valid_o), 1);
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    check("rst2_valid", 32'(valid_o), 0);
    check("rst2_ready", 32'(ready_o), 1);
    check("rst2_data", data_o, 0);
    check("rst2_sat", sat_count_o, 0);
    idle(6);
    check("rst2_no_stale", 32'(valid_o), 0);
    mag_i = 16'hFFFF; sign_i = 1'b0; valid_i = 1'b1;
    acc = 0; cyc = 0;
    while (acc < 65536 && cyc < 70000) begin
      @(negedge clk);
      if (ready_o) acc++;
      cyc++;
      @(posedge clk);
      #1;
    end
    valid_i = 1'b0;
    check("cnt_accepted", acc, 65536);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("cnt_stick", sat_count_o, 16'hFFFF);
    check("cnt_model", sat_count_o, exp_sat);
    @(posedge clk);
    #1 sat_clr_i = 1'b1; valid_i = 1'b1;
    @(posedge clk);
    #1 sat_clr_i = 1'b0; valid_i = 1'b0;
    @(negedge clk);
    check("clr_with_sat", sat_count_o, 1);
    @(posedge clk);
    #1 sat_clr_i = 1'b1;
    @(posedge clk);
    #1 sat_clr_i = 1'b0;
    @(negedge clk);
    check("clr_alone", sat_count_o, 0);
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/signed_rebuild.md
SIGNED_REBUILD -- requirements
Module: signed_rebuild

Interface
REQ-001 The module SHALL have parameter data_width, default 16, giving the sample width in bits.
REQ-002 The module SHALL have parameter sign_delay, default 0, legal 0..3, giving the number of accepted samples by which sign_i leads its magnitude.
REQ-003 The module SHALL have port clk_i, input, 1, the single clock; all logic on its rising edge.
REQ-004 The module SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port mag_i, input, data_width, unsigned magnitude sample.
REQ-006 The module SHALL have port sign_i, input, 1, sign of the sample (1 = negative).
REQ-007 The module SHALL have port valid_i, input, 1, mag_i/sign_i qualifier.
REQ-008 The module SHALL have port ready_o, output, 1, upstream may transfer.
REQ-009 The module SHALL have port data_o, output, data_width, two's-complement sample.
REQ-010 The module SHALL have port valid_o, output, 1, data_o qualifier.
REQ-011 The module SHALL have port ready_i, input, 1, downstream accepts.
REQ-012 The module SHALL have port sat_clr_i, input, 1, clears the saturation counter.
REQ-013 The module SHALL have port sat_count_o, output, 16, number of saturated samples.

Function
REQ-014 An input transfer SHALL occur on each edge where valid_i and ready_o are both 1; an output transfer SHALL occur on each edge where valid_o and ready_i are both 1.
REQ-015 The sign used for a transfer SHALL be sign_i delayed by sign_delay transfers (shift register advancing only on input transfers; reset contents 0); sign_delay 0 uses sign_i directly.
REQ-016 Conversion SHALL give: sign 0 and mag MSB 0 -> +mag; sign 0 and mag MSB 1 -> 2^(W-1)-1, saturated.
REQ-017 Conversion SHALL give: sign 1 and mag <= 2^(W-1) -> -mag (mag 0 -> 0; mag 2^(W-1) -> -2^(W-1), not saturated); sign 1 and mag > 2^(W-1) -> -2^(W-1), saturated.
REQ-018 A transferred sample SHALL be converted into a one-entry stage register on the transfer edge, then written into a 4-entry first-word-fall-through FIFO on the next edge.
REQ-019 With the FIFO empty and ready_i 1, a sample transferred at edge k SHALL appear on data_o with valid_o 1 after edge k+1 (2-cycle latency).
REQ-020 Samples SHALL leave in acceptance order; no sample is dropped or duplicated.
REQ-021 ready_o SHALL be 1 exactly when FIFO occupancy plus stage-register occupancy is below 4, and SHALL be computed from registers only.
REQ-022 A simultaneous FIFO write and read SHALL leave occupancy unchanged, including when the FIFO is full.
REQ-023 valid_o SHALL be 1 exactly when the FIFO is not empty; data_o SHALL hold the head entry stable while valid_o is 1 and ready_i is 0.
REQ-024 sat_count_o SHALL increment by 1 per saturated input transfer and SHALL stick at 0xFFFF.
REQ-025 sat_clr_i SHALL zero the counter; a clear and a saturating transfer on the same edge SHALL give 1.

Reset
REQ-026 On reset the FIFO, the stage register and the sign shift register SHALL be emptied; a sample in flight SHALL be discarded.
REQ-027 On reset, ready_o SHALL be 1 from the first edge with rst_i low, and valid_o, data_o and sat_count_o SHALL be 0.
REQ-028 During reset, inputs SHALL be ignored and no transfer SHALL occur.

Structure
REQ-029 The saturation limits (2^(W-1)-1 and -2^(W-1)), the FIFO depth constant 4, and the counter width 16 SHALL be defined in the shared package.
REQ-030 The FIFO SHALL be a separate sub-module, sync_fifo_fwft, parameterised by width and depth.

Verification
REQ-031 W=16, sign_delay 0, ready_i 1: inputs (5,0),(5,1),(0,1) -> data_o 5, 0xFFFB, 0x0000 at cycles k+2..k+4; sat_count_o stays 0.
REQ-032 Saturation: inputs (0x8000,0), (0x8000,1), (0x8001,1) -> outputs 0x7FFF, 0x8000, 0x8000; sat_count_o = 2.
REQ-033 Backpressure: ready_i 0, valid_i held 1 -> exactly 4 transfers, then ready_o 0; raise ready_i -> 4 samples out in order, and ready_o returns 1 one cycle after the first read.
REQ-034 sign_delay 2: sign sequence 1,0,0 with magnitudes 7,7,7 -> third output 0xFFF9.
REQ-035 Reset with 3 samples queued -> valid_o 0 and ready_o 1 after reset; no stale sample emerges.
REQ-036 Counter: drive 0x10000 saturating samples -> sat_count_o reads 0xFFFF; sat_clr_i with a concurrent saturating transfer -> 1.
